ula_seq: RTL
============

# ula_seq

Parametrised, handshaked successor to the 8-bit combinational ALU in the CPU datapath. It keeps the same 5-bit operation encoding and adds a configurable data width, registered outputs and status flags. MUL and DIV are iterative multi-cycle operations that return full-width results (high product half, remainder). It sits between the register file and the accumulator writeback, driven by the control unit through a start/busy/done handshake.

## Interface
- LARGURA, 8, operand/result width in bits (minimum 4)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- inicio  in  1  start request; sampled only while ocupado=0
- seletor  in  5  operation code, captured with inicio
- temp1  in  LARGURA  operand A, captured with inicio
- temp2  in  LARGURA  operand B, captured with inicio
- saida  out  LARGURA  result (low product half / quotient)
- saida_alta  out  LARGURA  high product half (MUL), remainder (DIV), else 0
- carryOut  out  1  carry/borrow/overflow flag
- zero  out  1  saida == 0
- negativo  out  1  saida[LARGURA-1]
- div_zero  out  1  DIV with temp2 == 0
- op_invalida  out  1  unrecognised seletor
- ocupado  out  1  iterative operation in progress
- pronto  out  1  one-cycle pulse: results valid and updated

## Operation
- Opcodes: 00100 ADD, 00101 SUB, 00110 MUL, 00111 DIV, 01000 AND, 01001 NAND, 01010 OR, 01011 XOR, 01100 CMP, 01101 NOT (~temp1).
- ADD: saida = low bits of the sum; carryOut = bit LARGURA of the (LARGURA+1)-bit sum.
- SUB: saida = temp1 - temp2 modulo 2^LARGURA; carryOut = borrow (temp1 < temp2, unsigned).
- MUL (unsigned, shift-add): {saida_alta, saida} = 2·LARGURA-bit product; carryOut = (saida_alta != 0).
- DIV (unsigned, restoring): saida = quotient, saida_alta = remainder.
- DIV with temp2 = 0: saida = all ones, saida_alta = temp1, div_zero = 1. No iteration.
- CMP (unsigned): saida = 1 if temp1 > temp2; all ones if temp1 < temp2; 0 if equal.
- Logic ops, CMP and NOT: carryOut = 0, saida_alta = 0.
- Unknown seletor: every result output and flag is 0 except op_invalida = 1 and zero = 1. pronto still pulses.
- All result outputs and flags hold their value until the next pronto.
- States:
  - OCIOSO: default state. inicio with MUL, or with DIV and temp2 != 0, goes to CALCULA. Any other inicio completes in place.
  - CALCULA: a down-counter runs from LARGURA. On the final iteration the block writes the outputs, pulses pronto and returns to OCIOSO.
- ocupado = (state == CALCULA).
- inicio while ocupado=1 is ignored. It is not queued.

## Timing
- Reset:
  - saida, saida_alta, carryOut, div_zero, op_invalida, ocupado and pronto are 0.
  - zero = 1 and negativo = 0.
  - State returns to OCIOSO and the counter to 0.
- Reset mid-CALCULA aborts the operation. pronto does not pulse, and outputs take their reset values.
- Single-cycle ops and DIV-by-zero: inicio sampled at edge k; outputs and pronto=1 are visible after edge k. Latency is 1 cycle.
- MUL/DIV: operands are loaded at edge k. Iterations occur at edges k+1 … k+LARGURA. Outputs and pronto=1 are visible after edge k+LARGURA. ocupado is high from after edge k until edge k+LARGURA.
- Back-to-back: inicio may be high in the same cycle as pronto. It is accepted at the next edge.
- pronto is high for exactly one cycle per accepted inicio.

## Structure
- Package ula_pkg holds:
  - the opcode localparams (OP_ADD … OP_NOT)
  - the state enum (OCIOSO, CALCULA)
- Sub-module ula_muldiv, parametrised by LARGURA: the shared shift-add multiplier / restoring divider datapath, with load, step and done ports.
- ula_seq keeps the FSM, the single-cycle ops, flag generation and the output registers.

## Test plan
- LARGURA=8, ADD 0xF0+0x20 → saida 0x10, carryOut 1, pronto 1 cycle after inicio. SUB 0x05-0x07 → 0xFE, carryOut 1, negativo 1.
- MUL 0xFF×0xFF → saida 0x01, saida_alta 0xFE, carryOut 1. ocupado high for 8 cycles, pronto after edge k+8.
- DIV 200/7 → saida 28, saida_alta 4. DIV 9/0 → saida 0xFF, saida_alta 9, div_zero 1, latency 1.
- CMP 3 vs 9 → 0xFF. CMP 9 vs 3 → 0x01. CMP 5 vs 5 → 0x00, zero 1. Opcode 11111 → op_invalida 1, pronto pulses.
- inicio pulsed during CALCULA is ignored, and the original result is unchanged. reset at iteration 4 gives no pronto and all outputs at reset values. The next MUL then runs correctly.
- LARGURA=16, MUL 0xFFFF×0x0002 → saida 0xFFFE, saida_alta 0x0001. Latency 16 cycles.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
package ula_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_NAND = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_CMP  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;

  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    CALCULA = 1'b1
  } estado_t;

endpackage

// File: rtl/ula_muldiv.sv
// Shared iterative datapath: LSB-first shift-add multiplier and restoring divider.
// res_lo/res_hi present the value the registers take on the current step.
module ula_muldiv #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               eh_div,
  input  logic [LARGURA-1:0] op_a,
  input  logic [LARGURA-1:0] op_b,
  output logic               done,
  output logic               div_ativo,
  output logic [LARGURA-1:0] res_lo,
  output logic [LARGURA-1:0] res_hi
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] CNT_INI = CW'(LARGURA);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  logic [LARGURA-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;

  logic [LARGURA:0]   soma_s, desloc_s;
  logic [LARGURA-1:0] dif_s, mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;
  logic               cabe_s;

  // One iteration of both algorithms; div_q selects which one is live.
  always_comb begin
    soma_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(LARGURA+1){1'b0}});
    mul_hi_s = soma_s[LARGURA:1];
    mul_lo_s = {soma_s[0], lo_q[LARGURA-1:1]};
    desloc_s = {hi_q, lo_q[LARGURA-1]};
    cabe_s   = (desloc_s >= {1'b0, b_q});
    dif_s    = desloc_s[LARGURA-1:0] - b_q;
    div_hi_s = cabe_s ? dif_s : desloc_s[LARGURA-1:0];
    div_lo_s = {lo_q[LARGURA-2:0], cabe_s};
    if (div_q) begin
      res_hi = div_hi_s;
      res_lo = div_lo_s;
    end else begin
      res_hi = mul_hi_s;
      res_lo = mul_lo_s;
    end
  end

  // Next-state for operand, partial-result and iteration counter registers.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      hi_d  = {LARGURA{1'b0}};
      lo_d  = op_a;
      b_d   = op_b;
      cnt_d = CNT_INI;
      div_d = eh_div;
    end else if (step) begin
      hi_d  = res_hi;
      lo_d  = res_lo;
      cnt_d = cnt_q - CNT_UM;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q  <= {LARGURA{1'b0}};
      lo_q  <= {LARGURA{1'b0}};
      b_q   <= {LARGURA{1'b0}};
      cnt_q <= {CW{1'b0}};
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign done      = (cnt_q == CNT_UM);
  assign div_ativo = div_q;

endmodule

// File: rtl/ula_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative MUL/DIV, registered
// results and flags that hold until the next pronto pulse.
module ula_seq
  import ula_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [4:0]         seletor,
  input  logic [LARGURA-1:0] temp1,
  input  logic [LARGURA-1:0] temp2,
  output logic [LARGURA-1:0] saida,
  output logic [LARGURA-1:0] saida_alta,
  output logic               carryOut,
  output logic               zero,
  output logic               negativo,
  output logic               div_zero,
  output logic               op_invalida,
  output logic               ocupado,
  output logic               pronto
);

  localparam logic [LARGURA-1:0] VAL_UM = {{(LARGURA-1){1'b0}}, 1'b1};

  estado_t estado_q, estado_d;
  logic [LARGURA-1:0] saida_q, saida_d, alta_q, alta_d;
  logic carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic dz_q, dz_d, inv_q, inv_d, pronto_q, pronto_d;

  logic               load_s, step_s, done_s, div_ativo_s, fim_s;
  logic [LARGURA-1:0] md_lo_s, md_hi_s, r_lo_s, r_hi_s;
  logic               r_c_s, r_dz_s, r_inv_s;

  ula_muldiv #(.LARGURA(LARGURA)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .load      (load_s),
    .step      (step_s),
    .eh_div    (seletor == OP_DIV),
    .op_a      (temp1),
    .op_b      (temp2),
    .done      (done_s),
    .div_ativo (div_ativo_s),
    .res_lo    (md_lo_s),
    .res_hi    (md_hi_s)
  );

  // FSM next state plus the result that completes on this cycle, if any.
  always_comb begin
    estado_d = estado_q;
    load_s   = 1'b0;
    step_s   = 1'b0;
    fim_s    = 1'b0;
    r_lo_s   = {LARGURA{1'b0}};
    r_hi_s   = {LARGURA{1'b0}};
    r_c_s    = 1'b0;
    r_dz_s   = 1'b0;
    r_inv_s  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          fim_s = 1'b1;
          case (seletor)
            OP_ADD:  {r_c_s, r_lo_s} = {1'b0, temp1} + {1'b0, temp2};
            OP_SUB: begin
              r_lo_s = temp1 - temp2;
              r_c_s  = (temp1 < temp2);
            end
            OP_MUL: begin
              fim_s    = 1'b0;
              load_s   = 1'b1;
              estado_d = CALCULA;
            end
            OP_DIV: begin
              if (temp2 == {LARGURA{1'b0}}) begin
                r_lo_s = {LARGURA{1'b1}};
                r_hi_s = temp1;
                r_dz_s = 1'b1;
              end else begin
                fim_s    = 1'b0;
                load_s   = 1'b1;
                estado_d = CALCULA;
              end
            end
            OP_AND:  r_lo_s = temp1 & temp2;
            OP_NAND: r_lo_s = ~(temp1 & temp2);
            OP_OR:   r_lo_s = temp1 | temp2;
            OP_XOR:  r_lo_s = temp1 ^ temp2;
            OP_CMP: begin
              if (temp1 > temp2) begin
                r_lo_s = VAL_UM;
              end else if (temp1 < temp2) begin
                r_lo_s = {LARGURA{1'b1}};
              end else begin
                r_lo_s = {LARGURA{1'b0}};
              end
            end
            OP_NOT:  r_lo_s = ~temp1;
            default: r_inv_s = 1'b1;
          endcase
        end else begin
          fim_s = 1'b0;
        end
      end
      CALCULA: begin
        step_s = 1'b1;
        if (done_s) begin
          fim_s    = 1'b1;
          estado_d = OCIOSO;
          r_lo_s   = md_lo_s;
          r_hi_s   = md_hi_s;
          r_c_s    = div_ativo_s ? 1'b0 : (md_hi_s != {LARGURA{1'b0}});
        end else begin
          estado_d = CALCULA;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Result registers only move when an operation completes.
  always_comb begin
    pronto_d = fim_s;
    if (fim_s) begin
      saida_d = r_lo_s;
      alta_d  = r_hi_s;
      carry_d = r_c_s;
      zero_d  = (r_lo_s == {LARGURA{1'b0}});
      neg_d   = r_lo_s[LARGURA-1];
      dz_d    = r_dz_s;
      inv_d   = r_inv_s;
    end else begin
      saida_d = saida_q;
      alta_d  = alta_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      inv_d   = inv_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      saida_q  <= {LARGURA{1'b0}};
      alta_q   <= {LARGURA{1'b0}};
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      saida_q  <= saida_d;
      alta_q   <= alta_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      inv_q    <= inv_d;
      pronto_q <= pronto_d;
    end
  end

  assign saida       = saida_q;
  assign saida_alta  = alta_q;
  assign carryOut    = carry_q;
  assign zero        = zero_q;
  assign negativo    = neg_q;
  assign div_zero    = dz_q;
  assign op_invalida = inv_q;
  assign pronto      = pronto_q;
  assign ocupado     = (estado_q == CALCULA);

endmodule
